// File: rtl/uart_disk_link.sv
// uart_disk_link: 8N1 full-duplex UART byte port behind the disk controller.
// Define UART_RX_FIFO_EN to buffer received bytes in a small FIFO.
module uart_disk_link #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int TX_GUARD      = 2,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dev_enable,
  input  logic       dev_we,
  input  logic [7:0] dev_data_out,
  output logic [7:0] dev_data_in,
  output logic       dev_write_done,
  output logic       dev_read_done,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       frame_err,
  output logic       tx_busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CMAX = (DIV > TX_GUARD) ? DIV : TX_GUARD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_TX_IDLE  = 3'd0;
  localparam logic [2:0] S_TX_START = 3'd1;
  localparam logic [2:0] S_TX_BITS  = 3'd2;
  localparam logic [2:0] S_TX_STOP  = 3'd3;
  localparam logic [2:0] S_TX_GUARD = 3'd4;

  localparam logic [1:0] S_RX_IDLE  = 2'd0;
  localparam logic [1:0] S_RX_START = 2'd1;
  localparam logic [1:0] S_RX_BITS  = 2'd2;
  localparam logic [1:0] S_RX_STOP  = 2'd3;

  logic [2:0]    tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick = tx_cnt == CW'(DIV - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= S_TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      unique case (tx_st)
        S_TX_IDLE: begin
          tx_cnt <= '0;
          if (dev_enable && dev_we) begin
            tx_sh  <= dev_data_out;
            tx_bit <= '0;
            tx_st  <= S_TX_START;
          end
        end
        S_TX_START: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_st  <= S_TX_BITS;
          end
        end
        S_TX_BITS: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_st <= S_TX_STOP;
          end
        end
        S_TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_st  <= (TX_GUARD == 0) ? S_TX_IDLE : S_TX_GUARD;
          end
        end
        S_TX_GUARD: begin
          // requests here are ignored so the controller can advance its byte
          if (tx_cnt == CW'(TX_GUARD - 1)) begin
            tx_cnt <= '0;
            tx_st  <= S_TX_IDLE;
          end
        end
        default: tx_st <= S_TX_IDLE;
      endcase
    end
  end

  always_comb begin
    uart_txd = 1'b1;
    unique case (1'b1)
      tx_st == S_TX_START: uart_txd = 1'b0;
      tx_st == S_TX_BITS:  uart_txd = tx_sh[0];
      default:             uart_txd = 1'b1;
    endcase
  end

  assign tx_busy        = tx_st != S_TX_IDLE;
  assign dev_write_done = (tx_st == S_TX_STOP) && tx_tick;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_s3;
  logic          rx_fall;
  logic [1:0]    rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_hold;
  logic          rx_tick;
  logic          rx_smp;
  logic          rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall  = rx_s3 && !rx_s2;
  assign rx_tick  = rx_cnt == CW'(DIV - 1);
  assign rx_smp   = (rx_st == S_RX_STOP) && !rx_hold && rx_tick;
  assign rx_valid = rx_smp && rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= S_RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_hold <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
      unique case (rx_st)
        S_RX_IDLE: begin
          rx_cnt  <= '0;
          rx_hold <= 1'b0;
          if (rx_fall) rx_st <= S_RX_START;
        end
        S_RX_START: begin
          // mid start bit: a high line here was only a glitch
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? S_RX_IDLE : S_RX_BITS;
          end
        end
        S_RX_BITS: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= S_RX_STOP;
          end
        end
        S_RX_STOP: begin
          if (rx_hold) begin
            rx_cnt <= '0;
            if (rx_s2) rx_st <= S_RX_IDLE;
          end else if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_s2) rx_st <= S_RX_IDLE;
            else       rx_hold <= 1'b1;
          end
        end
        default: rx_st <= S_RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= rx_smp && !rx_s2;
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_full  = fifo_cnt == (AW + 1)'(RX_FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  // the previous pop's pulse doubles as the one-cycle gap
  assign pop  = dev_enable && !dev_we && !fifo_empty && !dev_read_done;
  assign push = rx_valid && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      dev_data_in   <= '0;
      dev_read_done <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      dev_read_done <= pop;
      if (push) begin
        fifo_mem[wr_ptr] <= rx_sh;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        dev_data_in <= fifo_mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {AW'(0), push} - {AW'(0), pop};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_data_in   <= '0;
      dev_read_done <= 1'b0;
    end else begin
      dev_read_done <= 1'b0;
      if (rx_valid && dev_enable && !dev_we) begin
        dev_data_in   <= rx_sh;
        dev_read_done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_disk_link.sv
// tb_uart_disk_link: directed checks of TX framing, guard, burst and RX paths.
// Runs at 1 MHz / 100 kbaud so one bit is ten clocks.
module tb_uart_disk_link;

  logic       clk;
  logic       rst_n;
  logic       dev_enable;
  logic       dev_we;
  logic [7:0] dev_data_out;
  logic [7:0] dev_data_in;
  logic       dev_write_done;
  logic       dev_read_done;
  logic       uart_txd;
  logic       uart_rxd;
  logic       frame_err;
  logic       tx_busy;

  int n_vec;
  int n_err;
  int n_wd;
  int n_fe;
  int cyc;

  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  int         rxt [$];
  logic       tline [100];
  logic       tdone [100];

  uart_disk_link #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .TX_GUARD(2),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dev_enable(dev_enable),
    .dev_we(dev_we),
    .dev_data_out(dev_data_out),
    .dev_data_in(dev_data_in),
    .dev_write_done(dev_write_done),
    .dev_read_done(dev_read_done),
    .uart_txd(uart_txd),
    .uart_rxd(uart_rxd),
    .frame_err(frame_err),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && dev_write_done) n_wd <= n_wd + 1;
    if (rst_n && frame_err) n_fe <= n_fe + 1;
    if (rst_n && dev_read_done) begin
      rxq.push_back(dev_data_in);
      rxt.push_back(cyc);
    end
  end

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && !uart_txd) begin
        repeat (15) @(negedge clk);
        b[0] = uart_txd;
        for (int i = 1; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (10) @(negedge clk);
        txq.push_back(b);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (dev_write_done) ok = 1'b1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic       ok;
    logic [7:0] bb;
    logic [7:0] bst [4];
    int         d0;
    int         f0;
    int         sz;
    bst = '{8'h11, 8'h22, 8'h33, 8'h44};
    n_vec = 0;
    n_err = 0;
    n_wd = 0;
    n_fe = 0;
    cyc = 0;
    rst_n = 1'b0;
    dev_enable = 1'b0;
    dev_we = 1'b0;
    dev_data_out = 8'h00;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of a frame of zeros
    dev_enable = 1'b1;
    dev_we = 1'b1;
    dev_data_out = 8'h00;
    @(negedge clk);
    dev_enable = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_txd", uart_txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_wdone", dev_write_done, 1'b0);
    check("rst_rdone", dev_read_done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_din", dev_data_in, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", tx_busy, 1'b0);
    repeat (110) @(negedge clk);
    txq.delete();

    // single frame A5 with exact timing
    dev_data_out = 8'hA5;
    dev_enable = 1'b1;
    dev_we = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      tline[k] = uart_txd;
      tdone[k] = dev_write_done;
      if (k == 0) begin
        dev_enable = 1'b0;
        dev_data_out = 8'hFF;
      end
    end
    check("tx_start_lat", tline[0], 1'b0);
    for (int i = 0; i < 8; i++) bb[i] = tline[15 + 10 * i];
    check("tx_a5_bits", bb, 8'hA5);
    check("tx_stop", tline[95], 1'b1);
    check("tx_done_early", tdone[98], 1'b0);
    check("tx_done_at", tdone[99], 1'b1);
    d0 = 0;
    for (int k = 0; k < 100; k++) d0 += tdone[k];
    check("tx_done_cnt", d0, 1);

    // request one clock after done lands in the guard
    @(negedge clk);
    dev_enable = 1'b1;
    dev_data_out = 8'h00;
    @(negedge clk);
    dev_enable = 1'b0;
    @(negedge clk);
    check("guard_ignore", tx_busy, 1'b0);
    dev_enable = 1'b1;
    dev_data_out = 8'h5A;
    @(negedge clk);
    dev_enable = 1'b0;
    check("guard_acc_txd", uart_txd, 1'b0);
    check("guard_acc_busy", tx_busy, 1'b1);
    wait_done(ok);
    check("done_5a_to", ok, 1'b1);
    check("txq_5a_len", txq.size(), 2);
    check("txq_5a", (txq.size() > 1) ? txq[1] : 8'hxx, 8'h5A);
    repeat (5) @(negedge clk);

    // controller-style burst
    txq.delete();
    d0 = n_wd;
    dev_data_out = bst[0];
    dev_enable = 1'b1;
    dev_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(ok);
      check("burst_to", ok, 1'b1);
      if (i == 3) begin
        dev_enable = 1'b0;
      end else begin
        @(negedge clk);
        @(negedge clk);
        dev_data_out = bst[i + 1];
      end
    end
    repeat (5) @(negedge clk);
    check("burst_dones", n_wd - d0, 4);
    check("burst_len", txq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("burst_byte", (txq.size() > i) ? txq[i] : 8'hxx, bst[i]);
    repeat (20) @(negedge clk);
    check("burst_idle", tx_busy, 1'b0);

    // receive with the controller reading
    dev_we = 1'b0;
    dev_enable = 1'b1;
    rxq.delete();
    rxt.delete();
    send_rx(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_3c_len", rxq.size(), 1);
    check("rx_3c", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h3C);
    check("rx_3c_din", dev_data_in, 8'h3C);
`ifndef UART_RX_FIFO_EN
    dev_enable = 1'b0;
    send_rx(8'h96, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_drop_len", rxq.size(), 1);
    check("rx_drop_din", dev_data_in, 8'h3C);
    dev_enable = 1'b1;
`endif

    // bad stop bit, then a short glitch
    f0 = n_fe;
    sz = rxq.size();
    send_rx(8'h81, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_pulse", n_fe - f0, 1);
    check("ferr_no_rd", rxq.size(), sz);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (120) @(negedge clk);
    check("glitch_no_rd", rxq.size(), sz);
    check("glitch_no_fe", n_fe - f0, 1);
    check("glitch_din", dev_data_in, 8'h3C);
    send_rx(8'hC5, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_recover", dev_data_in, 8'hC5);

`ifdef UART_RX_FIFO_EN
    // fill past capacity while the controller is away
    dev_enable = 1'b0;
    repeat (5) @(negedge clk);
    rxq.delete();
    rxt.delete();
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    repeat (5) @(negedge clk);
    check("fifo_hold", rxq.size(), 0);
    dev_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("fifo_len", rxq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("fifo_byte", (rxq.size() > i) ? rxq[i] : 8'hxx, 8'(i + 1));
    for (int i = 1; i < 4; i++)
      check("fifo_gap", (rxt.size() > i) ? rxt[i] - rxt[i - 1] : -1, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
